// File: rtl/computer16_pkg.sv
// Shared constants and types for the 16-bit CPU fetch path.
package computer16_pkg;

  localparam int C16_AW = 16;
  localparam int C16_DW = 16;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [C16_AW-1:0] addr;
    logic [C16_DW-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO holding fetched {addr,instr} pairs for the decoder.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buffer #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents are only meaningful below count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the PC strobes, issues ROM reads at
// the PC address, buffers fetched instructions and handles jump redirects.
// Optional feature macro: FETCH_PERF_EN (adds saturating fetch/flush counters).
module fetch_ctrl
  import computer16_pkg::*;
#(
  parameter int AW    = C16_AW,
  parameter int DW    = C16_DW,
  parameter int DEPTH = 2
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_out,
  output logic [AW-1:0] pc_in,
  output logic          pc_load,
  output logic          pc_inc,
  output logic          rom_req,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ack,
  input  logic [DW-1:0] rom_data,
  input  logic          jump_valid,
  input  logic [AW-1:0] jump_target,
  output logic          instr_valid,
  output logic [DW-1:0] instr_data,
  output logic [AW-1:0] instr_addr,
  input  logic          instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]   perf_fetch_cnt,
  output logic [15:0]   perf_flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_t  state;
  logic [AW-1:0] held_addr;
  logic [CW-1:0] count;
  logic          accept;
  logic          pop;

  // Strobes are gated by rst_n so they drop the instant reset asserts.
  // In DISCARD the abandoned request must be kept alive at its old address,
  // since the PC has already moved to the jump target.
  assign rom_req  = rst_n && ((state == DISCARD) || (count < CW'(DEPTH)));
  assign rom_addr = (state == DISCARD) ? held_addr : pc_out;
  assign accept   = rst_n && (state == FETCH) && rom_req && rom_ack && !jump_valid;
  assign pc_inc   = accept;
  assign pc_load  = rst_n && jump_valid;
  assign pc_in    = pc_load ? jump_target : '0;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;

  // Fetch FSM: track whether an old-path ROM request is still outstanding.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   if (jump_valid && rom_req && !rom_ack) state <= DISCARD;
        DISCARD: if (rom_ack) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Remember the address of the live request so DISCARD can hold it stable.
  always_ff @(posedge clock) begin
    if (rom_req) held_addr <= rom_addr;
  end

  fetch_buffer #(
    .W     (AW + DW),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clock     (clock),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data ({rom_addr, rom_data}),
    .pop       (pop),
    .flush     (pc_load),
    .head_data ({instr_addr, instr_data}),
    .count     (count)
  );

`ifdef FETCH_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating event counters for accepted fetches and redirects.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (accept)  perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
      if (pc_load) perf_flush_cnt <= sat_inc(perf_flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: models the PC register and a variable-latency ROM,
// checks the delivered instruction stream against program order.
module tb_fetch_ctrl;

  logic        clock = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] pc_out, pc_in, rom_addr, rom_data, jump_target, instr_data, instr_addr;
  logic        pc_load, pc_inc, rom_req, rom_ack, jump_valid, instr_valid, instr_ready;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt, perf_flush_cnt;
`endif

  always #5 clock = ~clock;

  fetch_ctrl dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .pc_out      (pc_out),
    .pc_in       (pc_in),
    .pc_load     (pc_load),
    .pc_inc      (pc_inc),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_addr  (instr_addr),
    .instr_ready (instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // PC register environment
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n)       pc_out <= 16'h0000;
    else if (pc_load) pc_out <= pc_in;
    else if (pc_inc)  pc_out <= pc_out + 16'd1;
  end

  int tests = 0;
  int fails = 0;

  // ROM model state
  bit          busy;
  int          wait_left;
  logic [15:0] req_addr;
  int          rom_delay;

  // Program-order scoreboard
  logic [15:0] exp_next;
  int          pops;

  // Samples of one cycle
  logic        s_rom_req, s_rom_ack, s_pc_load, s_pc_inc, s_instr_valid;
  logic [15:0] s_rom_addr, s_pc_in, s_instr_addr, s_pc_out;

  function automatic logic [15:0] rom_fn(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // One clock cycle: entered and left just after a falling edge.
  task automatic step();
    #1;
    if (busy) begin
      tests++;
      if (rom_req !== 1'b1 || rom_addr !== req_addr) begin
        fails++;
        $display("FAIL rom_hold: req=%b addr=%h, required req=1 addr=%h", rom_req, rom_addr, req_addr);
      end
    end else if (rom_req === 1'b1) begin
      busy      = 1'b1;
      wait_left = rom_delay;
      req_addr  = rom_addr;
    end
    rom_ack  = busy && (wait_left == 0);
    rom_data = rom_ack ? rom_fn(rom_addr) : 16'h0000;
    #1;
    s_rom_req = rom_req;  s_rom_addr = rom_addr;  s_rom_ack = rom_ack;
    s_pc_load = pc_load;  s_pc_inc = pc_inc;      s_pc_in = pc_in;
    s_instr_valid = instr_valid;  s_instr_addr = instr_addr;  s_pc_out = pc_out;
    tests++;
    if (pc_load === 1'b1 && pc_inc === 1'b1) begin
      fails++;
      $display("FAIL strobe_excl: pc_load=%b pc_inc=%b, required not both 1", pc_load, pc_inc);
    end
    if (instr_valid === 1'b1 && instr_ready) begin
      tests++;
      if (instr_addr !== exp_next || instr_data !== rom_fn(exp_next)) begin
        fails++;
        $display("FAIL stream: addr=%h data=%h, required addr=%h data=%h",
                 instr_addr, instr_data, exp_next, rom_fn(exp_next));
      end
      exp_next = exp_next + 16'd1;
      pops++;
    end
    if (jump_valid) exp_next = jump_target;
    @(posedge clock);
    if (busy) begin
      if (rom_ack) busy = 1'b0;
      else wait_left--;
    end
    @(negedge clock);
    rom_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    rst_n = 1'b0; jump_valid = 1'b1; jump_target = 16'h1234; instr_ready = 1'b1;
    #1;
    tests++; if (rom_req !== 1'b0) begin fails++; $display("FAIL rst_rom_req: got %b want 0", rom_req); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
    tests++; if (pc_load !== 1'b0) begin fails++; $display("FAIL rst_pc_load: got %b want 0", pc_load); end
    tests++; if (pc_inc !== 1'b0) begin fails++; $display("FAIL rst_pc_inc: got %b want 0", pc_inc); end
    tests++; if (pc_in !== 16'h0000) begin fails++; $display("FAIL rst_pc_in: got %h want 0000", pc_in); end
    @(posedge clock);
    @(negedge clock);
    jump_valid = 1'b0; jump_target = 16'h0000; instr_ready = 1'b0;
    rst_n = 1'b1; busy = 1'b0; exp_next = 16'h0000; rom_ack = 1'b0; rom_delay = 0;
  endtask

  task automatic test_sequential();
    test_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (s_rom_req !== 1'b1 || s_rom_addr !== 16'(i)) begin fails++; $display("FAIL t1_rom: req=%b addr=%h want 1 %h", s_rom_req, s_rom_addr, 16'(i)); end
      tests++; if (s_pc_inc !== 1'b1) begin fails++; $display("FAIL t1_pc_inc: got %b want 1", s_pc_inc); end
      if (i > 0) begin
        tests++; if (s_instr_valid !== 1'b1 || s_instr_addr !== 16'(i-1)) begin fails++; $display("FAIL t1_head: valid=%b addr=%h want 1 %h", s_instr_valid, s_instr_addr, 16'(i-1)); end
      end
    end
  endtask

  task automatic test_full();
    test_reset();
    step(); step(); step();
    tests++; if (s_rom_req !== 1'b0) begin fails++; $display("FAIL t2_full_req: got %b want 0", s_rom_req); end
    tests++; if (s_pc_out !== 16'h0002) begin fails++; $display("FAIL t2_pc_hold: got %h want 0002", s_pc_out); end
    tests++; if (s_instr_addr !== 16'h0000) begin fails++; $display("FAIL t2_head0: got %h want 0000", s_instr_addr); end
    instr_ready = 1'b1;
    step();
    tests++; if (s_instr_addr !== 16'h0000 || s_rom_req !== 1'b0) begin fails++; $display("FAIL t2_pop0: addr=%h req=%b want 0000 0", s_instr_addr, s_rom_req); end
    step();
    tests++; if (s_instr_addr !== 16'h0001 || s_rom_req !== 1'b1 || s_rom_addr !== 16'h0002) begin fails++; $display("FAIL t2_resume: head=%h req=%b addr=%h want 0001 1 0002", s_instr_addr, s_rom_req, s_rom_addr); end
    step();
    tests++; if (s_instr_addr !== 16'h0002) begin fails++; $display("FAIL t2_head2: got %h want 0002", s_instr_addr); end
  endtask

  task automatic test_jump_idle();
    test_reset();
    step(); step(); step();
    jump_valid = 1'b1; jump_target = 16'h0100;
    step();
    tests++; if (s_pc_load !== 1'b1 || s_pc_in !== 16'h0100 || s_pc_inc !== 1'b0) begin fails++; $display("FAIL t3_jump: load=%b in=%h inc=%b want 1 0100 0", s_pc_load, s_pc_in, s_pc_inc); end
    jump_valid = 1'b0;
    step();
    tests++; if (s_instr_valid !== 1'b0) begin fails++; $display("FAIL t3_flushed: valid=%b want 0", s_instr_valid); end
    tests++; if (s_rom_req !== 1'b1 || s_rom_addr !== 16'h0100) begin fails++; $display("FAIL t3_next_req: req=%b addr=%h want 1 0100", s_rom_req, s_rom_addr); end
    tests++; if (s_pc_load !== 1'b0) begin fails++; $display("FAIL t3_load_pulse: got %b want 0", s_pc_load); end
`ifdef FETCH_PERF_EN
    tests++; if (perf_fetch_cnt !== 16'd3) begin fails++; $display("FAIL perf_fetch: got %0d want 3", perf_fetch_cnt); end
    tests++; if (perf_flush_cnt !== 16'd1) begin fails++; $display("FAIL perf_flush: got %0d want 1", perf_flush_cnt); end
`endif
  endtask

  task automatic test_jump_pending();
    test_reset();
    instr_ready = 1'b1;
    jump_valid = 1'b1; jump_target = 16'h0005;
    step();
    tests++; if (s_pc_inc !== 1'b0) begin fails++; $display("FAIL t4_setup_inc: got %b want 0", s_pc_inc); end
    rom_delay = 3; jump_target = 16'h0100;
    step();
    tests++; if (s_rom_addr !== 16'h0005 || s_pc_load !== 1'b1) begin fails++; $display("FAIL t4_req5: addr=%h load=%b want 0005 1", s_rom_addr, s_pc_load); end
    jump_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (s_rom_req !== 1'b1 || s_rom_addr !== 16'h0005 || s_pc_inc !== 1'b0) begin fails++; $display("FAIL t4_discard: req=%b addr=%h inc=%b want 1 0005 0", s_rom_req, s_rom_addr, s_pc_inc); end
    end
    rom_delay = 0;
    step();
    tests++; if (s_rom_addr !== 16'h0100 || s_pc_inc !== 1'b1 || s_instr_valid !== 1'b0) begin fails++; $display("FAIL t4_target: addr=%h inc=%b valid=%b want 0100 1 0", s_rom_addr, s_pc_inc, s_instr_valid); end
    step();
    tests++; if (s_instr_valid !== 1'b1 || s_instr_addr !== 16'h0100) begin fails++; $display("FAIL t4_head: valid=%b addr=%h want 1 0100", s_instr_valid, s_instr_addr); end
  endtask

  task automatic test_jump_ack();
    test_reset();
    step();
    jump_valid = 1'b1; jump_target = 16'h0200;
    step();
    tests++; if (s_pc_inc !== 1'b0 || s_pc_load !== 1'b1 || s_pc_in !== 16'h0200) begin fails++; $display("FAIL t5_jump: inc=%b load=%b in=%h want 0 1 0200", s_pc_inc, s_pc_load, s_pc_in); end
    jump_valid = 1'b0;
    step();
    tests++; if (s_rom_addr !== 16'h0200 || s_instr_valid !== 1'b0) begin fails++; $display("FAIL t5_next: addr=%h valid=%b want 0200 0", s_rom_addr, s_instr_valid); end
    step();
    tests++; if (s_instr_valid !== 1'b1 || s_instr_addr !== 16'h0200) begin fails++; $display("FAIL t5_head: valid=%b addr=%h want 1 0200", s_instr_valid, s_instr_addr); end
  endtask

  task automatic test_reset_mid();
    test_reset();
    step();
    rom_delay = 3;
    step();
    rst_n = 1'b0;
    #1;
    tests++; if (rom_req !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL t6_async: req=%b valid=%b want 0 0", rom_req, instr_valid); end
    rom_ack = 1'b1; rom_data = 16'hDEAD;
    @(posedge clock);
    @(negedge clock);
    rom_ack = 1'b0; rst_n = 1'b1; busy = 1'b0; exp_next = 16'h0000;
    rom_delay = 0; instr_ready = 1'b1;
    step();
    tests++; if (s_instr_valid !== 1'b0 || s_rom_req !== 1'b1 || s_rom_addr !== 16'h0000) begin fails++; $display("FAIL t6_restart: valid=%b req=%b addr=%h want 0 1 0000", s_instr_valid, s_rom_req, s_rom_addr); end
    step();
    tests++; if (s_instr_valid !== 1'b1 || s_instr_addr !== 16'h0000) begin fails++; $display("FAIL t6_head: valid=%b addr=%h want 1 0000", s_instr_valid, s_instr_addr); end
  endtask

  task automatic test_random();
    test_reset();
    pops = 0;
    for (int c = 0; c < 2000; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      jump_valid  = ($urandom_range(0, 15) == 0);
      jump_target = 16'($urandom);
      rom_delay   = $urandom_range(0, 3);
      step();
    end
    jump_valid = 1'b0;
    tests++; if (pops < 200) begin fails++; $display("FAIL rand_progress: pops=%0d want >= 200", pops); end
  endtask

  initial begin
    instr_ready = 1'b0; jump_valid = 1'b0; jump_target = 16'h0000;
    rom_ack = 1'b0; rom_data = 16'h0000; busy = 1'b0; wait_left = 0;
    req_addr = 16'h0000; rom_delay = 0; exp_next = 16'h0000; pops = 0;
    test_sequential();
    test_full();
    test_jump_idle();
    test_jump_pending();
    test_jump_ack();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
